// File: rtl/sf2_clk_rst_ctrl_pkg.sv
// Shared types and defaults for the SF2 clock/reset controller.
// Holds the reset-sequence state encoding and the board-level parameter defaults.
package sf2_clk_rst_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_HOLD  = 2'd1,
      ST_RUN   = 2'd2
   } rst_state_t;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_RST_HOLD    = 16;
   localparam int DEF_DIV_W       = 4;
   localparam int DEF_DEB_CYCLES  = 50000;
   localparam int DEF_HB_LOG2     = 25;

   // Bits needed for a counter that must reach max_value (at least one bit).
   function automatic int cnt_width(input int max_value);
      return (max_value < 1) ? 1 : $clog2(max_value + 1);
   endfunction

endpackage

// File: rtl/sf2_debounce.sv
// Synchronizer plus debouncer for one bouncing push button.
// level follows the synchronized input once it has been stable for DEB_CYCLES cycles.
module sf2_debounce
   import sf2_clk_rst_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic level,
   output logic rise
);

   localparam int            CW       = cnt_width(DEB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic [CW-1:0]          cnt_reg;
   logic                   synced;

   assign synced = sync_reg[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], in};
      end
   end

   // Any cycle where the input agrees with the accepted level restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
         level   <= 1'b0;
         rise    <= 1'b0;
      end else begin
         rise <= 1'b0;
         if (synced == level) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            level   <= synced;
            rise    <= synced;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sf2_clk_rst_ctrl.sv
// Reset sequencer, clock-enable divider / single-step, ready flag and heartbeat
// for a core running from the SF2 fabric oscillator.
module sf2_clk_rst_ctrl
   import sf2_clk_rst_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int RST_HOLD    = DEF_RST_HOLD,
   parameter int DIV_W       = DEF_DIV_W,
   parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
   parameter int HB_LOG2     = DEF_HB_LOG2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] div_sel,
   input  logic             step_mode,
   input  logic             step_btn,
   output logic             rst_out,
   output logic             clk_en,
   output logic             ready,
   output logic             heartbeat
);

   localparam int                CNT_W     = (1 << DIV_W) - 1;
   localparam int                HOLD_W    = cnt_width(RST_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

   rst_state_t             state_reg;
   logic [HOLD_W-1:0]      hold_cnt_reg;
   logic [SYNC_STAGES-2:0] rel_sync_reg;
   logic [SYNC_STAGES-1:0] mode_sync_reg;
   logic                   step_mode_s;
   logic                   step_level;
   logic                   step_rise;
   logic [CNT_W-1:0]       div_cnt_reg;
   logic [CNT_W-1:0]       div_limit;
   logic [HB_LOG2-1:0]     hb_cnt_reg;

   // The state register itself acts as the last stage of the release synchronizer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rel_sync_reg <= '0;
      end else begin
         rel_sync_reg[0] <= 1'b1;
         for (int i = 1; i < SYNC_STAGES - 1; i++) begin
            rel_sync_reg[i] <= rel_sync_reg[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_sync_reg <= '0;
      end else begin
         mode_sync_reg <= {mode_sync_reg[SYNC_STAGES-2:0], step_mode};
      end
   end

   assign step_mode_s = mode_sync_reg[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_RESET;
         hold_cnt_reg <= '0;
         rst_out      <= 1'b1;
         ready        <= 1'b0;
      end else begin
         case (state_reg)
            ST_RESET: begin
               rst_out <= 1'b1;
               ready   <= 1'b0;
               if (rel_sync_reg[SYNC_STAGES-2]) begin
                  state_reg    <= ST_HOLD;
                  hold_cnt_reg <= '0;
               end
            end
            ST_HOLD: begin
               if (hold_cnt_reg == HOLD_LAST) begin
                  state_reg <= ST_RUN;
                  rst_out   <= 1'b0;
                  ready     <= 1'b1;
               end else begin
                  hold_cnt_reg <= hold_cnt_reg + 1'b1;
               end
            end
            ST_RUN: begin
               rst_out <= 1'b0;
               ready   <= 1'b1;
            end
            default: begin
               state_reg <= ST_RESET;
               rst_out   <= 1'b1;
               ready     <= 1'b0;
            end
         endcase
      end
   end

   sf2_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
   ) u_step_deb (
      .clk   (clk),
      .rst   (rst),
      .in    (step_btn),
      .level (step_level),
      .rise  (step_rise)
   );

   // 2^div_sel - 1 without needing a wider intermediate for div_sel = 2^DIV_W-1.
   assign div_limit = ~({CNT_W{1'b1}} << div_sel);

   // Using >= makes a lowered div_sel fire on the next cycle instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_reg <= '0;
         clk_en      <= 1'b0;
      end else begin
         clk_en <= 1'b0;
         if (state_reg != ST_RUN || step_mode_s) begin
            div_cnt_reg <= '0;
            if (state_reg == ST_RUN) begin
               clk_en <= step_rise & step_level;
            end
         end else if (div_cnt_reg >= div_limit) begin
            div_cnt_reg <= '0;
            clk_en      <= 1'b1;
         end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hb_cnt_reg <= '0;
         heartbeat  <= 1'b0;
      end else if (state_reg != ST_RESET) begin
         hb_cnt_reg <= hb_cnt_reg + 1'b1;
         if (&hb_cnt_reg) begin
            heartbeat <= ~heartbeat;
         end
      end
   end

endmodule
